// File: rtl/ls161_cascade_pkg.sv
// Shared constants and helpers for the LS161-style cascaded counter chain.
// Stage width and terminal count live here so stage and top agree.
package ls161_cascade_pkg;

   localparam int          STAGE_W    = 4;
   localparam logic [3:0]  TERM_COUNT = 4'hF;

   // Modulo-16 increment; the natural 4-bit overflow gives the 15 -> 0 wrap.
   function automatic logic [STAGE_W-1:0] next_count(input logic [STAGE_W-1:0] cur);
      return cur + 4'd1;
   endfunction

   // Ripple carry of one stage: terminal count gated by that stage's ENT.
   function automatic logic stage_carry(input logic [STAGE_W-1:0] cur, input logic ent);
      return ent && (cur == TERM_COUNT);
   endfunction

endpackage

// File: rtl/ls161_stage.sv
// One 74LS161 4-bit synchronous counter: async clear, sync load, ENP/ENT, RCO.
// Clear wins over everything; load wins over count; RCO is purely combinational.
module ls161_stage
   import ls161_cascade_pkg::*;
(
   input  logic               CLK,
   input  logic               CLR_L,
   input  logic               LOAD_L,
   input  logic               ENP,
   input  logic               ENT,
   input  logic [STAGE_W-1:0] D,
   output logic [STAGE_W-1:0] Q,
   output logic               RCO
);

   logic [STAGE_W-1:0] count;

   always_ff @(posedge CLK or negedge CLR_L) begin
      if (!CLR_L) begin
         count <= '0;
      end else if (!LOAD_L) begin
         count <= D;
      end else if (ENP && ENT) begin
         count <= next_count(count);
      end
   end

   assign Q   = count;
   // ENP and LOAD_L deliberately play no part here, matching the real part.
   assign RCO = stage_carry(count, ENT);

endmodule

// File: rtl/ls161_cascade.sv
// Chain of STAGES LS161 counters forming one 4*STAGES-bit synchronous counter.
// Each stage's RCO drives the next stage's ENT; ENP, LOAD_L and CLR_L are shared.
module ls161_cascade
   import ls161_cascade_pkg::*;
#(
   parameter int STAGES = 3
) (
   input  logic                      CLK,
   input  logic                      CLR_L,
   input  logic                      LOAD_L,
   input  logic                      ENP,
   input  logic                      ENT,
   input  logic [STAGE_W*STAGES-1:0] D,
   output logic [STAGE_W*STAGES-1:0] Q,
   output logic [STAGES-1:0]         STAGE_RCO,
   output logic                      RCO
);

   logic [STAGES-1:0] ent_chain;

   assign ent_chain[0] = ENT;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // Carry lookahead: stage k counts only when every lower stage is at 15.
      if (k > 0) begin : g_link
         assign ent_chain[k] = STAGE_RCO[k-1];
      end

      ls161_stage u_stage (
         .CLK    (CLK),
         .CLR_L  (CLR_L),
         .LOAD_L (LOAD_L),
         .ENP    (ENP),
         .ENT    (ent_chain[k]),
         .D      (D[STAGE_W*k +: STAGE_W]),
         .Q      (Q[STAGE_W*k +: STAGE_W]),
         .RCO    (STAGE_RCO[k])
      );
   end

   assign RCO = STAGE_RCO[STAGES-1];

endmodule
